// File: rtl/hazard_control_unit.sv
// Hazard control for the 5-stage LEGv8 pipeline: load-use and CBZ/CBNZ stalls,
// taken-branch IF/ID flush, and saturating stall/flush cycle counters.
module hazard_control_unit #(
    parameter int unsigned CNT_W    = 32,
    parameter logic [4:0]  ZERO_REG = 5'd31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_cbz,
    input  logic             id_branch_taken,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } dst_t;

    localparam dst_t BUBBLE = '{rd: ZERO_REG, regwrite: 1'b0, memread: 1'b0};

    dst_t ex_q;
    dst_t mem_q;
    logic load_use;
    logic cbz_hazard;

    function automatic logic match(input dst_t x, input logic [4:0] r);
        return x.regwrite && (x.rd != ZERO_REG) && (x.rd == r);
    endfunction

    // Hazard detection and pipeline control; outputs follow ID inputs with no latency
    always_comb begin
        load_use    = 1'b0;
        cbz_hazard  = 1'b0;
        stall       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;

        load_use   = id_valid && ex_q.memread &&
                     ((id_use_rn && match(ex_q, id_rn)) || (id_use_rm && match(ex_q, id_rm)));
        // A load two ahead is still in MEM, so CBZ must wait for its writeback value
        cbz_hazard = id_valid && id_cbz &&
                     (match(ex_q, id_rm) || (mem_q.memread && match(mem_q, id_rm)));
        stall      = load_use || cbz_hazard;

        if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_valid && id_branch_taken) begin
            ifid_flush  = 1'b1;
        end
    end

    // Shadow copy of the EX/MEM destination info
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
        end else begin
            mem_q <= ex_q;
            if (id_valid && !stall) begin
                ex_q <= '{rd: id_rd, regwrite: id_regwrite, memread: id_memread};
            end else begin
                ex_q <= BUBBLE;
            end
        end
    end

    // Saturating performance counters; clear wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else if (cnt_clear) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (ifid_flush && !(&flush_cycles)) begin
                flush_cycles <= flush_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: expected control/counter vectors are
// queued as each ID instruction is driven and compared when sampled.
module tb_hazard_control_unit;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic             id_use_rn;
    logic             id_use_rm;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_cbz;
    logic             id_branch_taken;
    logic             cnt_clear;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             stall;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;

    hazard_control_unit #(.CNT_W(CNT_W), .ZERO_REG(5'd31)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_use_rn       (id_use_rn),
        .id_use_rm       (id_use_rm),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .id_cbz          (id_cbz),
        .id_branch_taken (id_branch_taken),
        .cnt_clear       (cnt_clear),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_bubble     (idex_bubble),
        .ifid_flush      (ifid_flush),
        .stall           (stall),
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
    );

    always #5 clk = ~clk;

    // {stall, pc_write, ifid_write, idex_bubble, ifid_flush, stall_cycles, flush_cycles}
    logic [12:0] exp_q[$];
    string       tag_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [CNT_W-1:0] exp_sc = '0;
    logic [CNT_W-1:0] exp_fc = '0;

    task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                          input logic urn, input logic urm, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic cb, input logic tk);
        id_valid = v; id_rn = rn; id_rm = rm; id_use_rn = urn; id_use_rm = urm;
        id_rd = rd; id_regwrite = rw; id_memread = mr; id_cbz = cb; id_branch_taken = tk;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ldur(input logic [4:0] rd, input logic [4:0] rn);
        set_id(1'b1, rn, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic add(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                       input logic urn, input logic urm);
        set_id(1'b1, rn, rm, urn, urm, rd, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cbz(input logic [4:0] rt, input logic tk);
        set_id(1'b1, 5'd0, rt, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, tk);
    endtask

    task automatic push_exp(input string tag, input logic e_stall, input logic e_flush);
        exp_q.push_back({e_stall, !e_stall, !e_stall, e_stall, e_flush, exp_sc, exp_fc});
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        logic [12:0] obs;
        logic [12:0] e;
        string       t;
        obs = {stall, pc_write, ifid_write, idex_bubble, ifid_flush, stall_cycles, flush_cycles};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h required=entry", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h required=%h (stall,pcw,ifidw,bub,flush,sc,fc)", t, obs, e);
            end
        end
    endtask

    // One pipeline cycle: queue expectation, sample mid-cycle, advance the counter model
    task automatic step(input string tag, input logic e_stall, input logic e_flush);
        push_exp(tag, e_stall, e_flush);
        @(negedge clk);
        check_out();
        if (cnt_clear) begin
            exp_sc = '0;
            exp_fc = '0;
        end else begin
            if (e_stall && exp_sc != '1) exp_sc = exp_sc + CNT_W'(1);
            if (e_flush && exp_fc != '1) exp_fc = exp_fc + CNT_W'(1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cnt_clear = 1'b0;
        nop();
        step("reset_state", 1'b0, 1'b0);
        reset = 1'b0;

        // Load-use on rn: exactly one stall
        ldur(5'd2, 5'd1);                          step("lu_ldur", 1'b0, 1'b0);
        add(5'd3, 5'd2, 5'd4, 1'b1, 1'b0);         step("lu_add_stall", 1'b1, 1'b0);
        add(5'd3, 5'd2, 5'd4, 1'b1, 1'b0);         step("lu_add_go", 1'b0, 1'b0);

        // CBZ after ALU op: one stall
        add(5'd5, 5'd1, 5'd2, 1'b1, 1'b1);         step("alu_add", 1'b0, 1'b0);
        cbz(5'd5, 1'b0);                           step("cbz_alu_stall", 1'b1, 1'b0);
        cbz(5'd5, 1'b0);                           step("cbz_alu_go", 1'b0, 1'b0);

        // CBZ directly after load: two stalls
        ldur(5'd5, 5'd1);                          step("cbz_ld_ldur", 1'b0, 1'b0);
        cbz(5'd5, 1'b0);                           step("cbz_ld_stall1", 1'b1, 1'b0);
        cbz(5'd5, 1'b0);                           step("cbz_ld_stall2", 1'b1, 1'b0);
        cbz(5'd5, 1'b0);                           step("cbz_ld_go", 1'b0, 1'b0);

        // CBZ two after load: one stall
        ldur(5'd6, 5'd1);                          step("cbz_ld2_ldur", 1'b0, 1'b0);
        add(5'd7, 5'd1, 5'd2, 1'b1, 1'b1);         step("cbz_ld2_add", 1'b0, 1'b0);
        cbz(5'd6, 1'b0);                           step("cbz_ld2_stall", 1'b1, 1'b0);
        cbz(5'd6, 1'b0);                           step("cbz_ld2_go", 1'b0, 1'b0);

        // XZR destination and unused operand never stall
        ldur(5'd31, 5'd1);                         step("xzr_ldur", 1'b0, 1'b0);
        add(5'd3, 5'd31, 5'd31, 1'b1, 1'b1);       step("xzr_add", 1'b0, 1'b0);
        ldur(5'd2, 5'd1);                          step("unused_ldur", 1'b0, 1'b0);
        add(5'd3, 5'd2, 5'd4, 1'b0, 1'b1);         step("unused_rn_add", 1'b0, 1'b0);

        // Taken branch without hazard, then taken branch held behind a stall
        cbz(5'd9, 1'b1);                           step("taken_flush", 1'b0, 1'b1);
        nop();                                     step("taken_after", 1'b0, 1'b0);
        add(5'd8, 5'd1, 5'd2, 1'b1, 1'b1);         step("pend_add", 1'b0, 1'b0);
        cbz(5'd8, 1'b1);                           step("pend_taken_stall", 1'b1, 1'b0);
        cbz(5'd8, 1'b1);                           step("pend_taken_flush", 1'b0, 1'b1);
        nop();                                     step("pend_after", 1'b0, 1'b0);

        // Drive stall_cycles into saturation
        for (int k = 0; k < 12; k++) begin
            add(5'd10, 5'd1, 5'd2, 1'b1, 1'b1);    step("sat_add", 1'b0, 1'b0);
            cbz(5'd10, 1'b0);                      step("sat_cbz_stall", 1'b1, 1'b0);
            cbz(5'd10, 1'b0);                      step("sat_cbz_go", 1'b0, 1'b0);
        end
        checks++;
        assert (stall_cycles === 4'hF) else begin
            failures++;
            $error("FAIL sat_hold observed=%h required=%h", stall_cycles, 4'hF);
        end

        // Clear coincident with a stall cycle
        add(5'd11, 5'd1, 5'd2, 1'b1, 1'b1);        step("clr_add", 1'b0, 1'b0);
        cbz(5'd11, 1'b0); cnt_clear = 1'b1;        step("clr_stall", 1'b1, 1'b0);
        cnt_clear = 1'b0;                          step("clr_after", 1'b0, 1'b0);

        // Reset in the second CBZ-after-load stall cycle
        ldur(5'd12, 5'd1);                         step("rst_ldur", 1'b0, 1'b0);
        cbz(5'd12, 1'b0);                          step("rst_stall1", 1'b1, 1'b0);
        cbz(5'd12, 1'b0);
        push_exp("rst_stall2", 1'b1, 1'b0);
        @(negedge clk);
        check_out();
        #2;
        reset = 1'b1;
        #1;
        exp_sc = '0;
        exp_fc = '0;
        push_exp("rst_async", 1'b0, 1'b0);
        check_out();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("rst_release", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer-side companion to the EX-stage forwarding logic in the 5-stage LEGv8 pipeline. Forwarding covers most RAW hazards; this block handles the ones forwarding cannot.
- Load-use hazards: stalls IF/ID and injects an ID/EX bubble.
- CBZ/CBNZ hazards: CBZ/CBNZ resolves in ID, so the block stalls it until its operand reaches a forwardable point.
- Taken branches: flushes IF/ID.
- Keeps its own shadow copy of the EX- and MEM-stage destination info, plus saturating stall/flush performance counters.

Parameters:
CNT_W, 32, width of the stall_cycles and flush_cycles counters
ZERO_REG, 5'd31, register index never treated as a hazard source (XZR)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
id_valid  input  1  ID stage holds a real instruction
id_rn  input  5  first source register
id_rm  input  5  second source register; for CBZ/CBNZ, the tested register
id_use_rn  input  1  instruction reads id_rn
id_use_rm  input  1  instruction reads id_rm
id_rd  input  5  destination register
id_regwrite  input  1  instruction writes id_rd
id_memread  input  1  instruction is LDUR
id_cbz  input  1  instruction is CBZ/CBNZ
id_branch_taken  input  1  branch resolved taken in ID this cycle
cnt_clear  input  1  synchronous clear of both counters
pc_write  output  1  PC register enable
ifid_write  output  1  IF/ID register enable
idex_bubble  output  1  zero the control fields entering ID/EX
ifid_flush  output  1  zero IF/ID on the next edge
stall  output  1  hazard stall this cycle
stall_cycles  output  CNT_W  saturating count of stall cycles
flush_cycles  output  CNT_W  saturating count of flush cycles

Behaviour:
- Shadow registers: ex_{rd, regwrite, memread} and mem_{rd, regwrite, memread}.
- On reset (async): all regwrite/memread bits 0, rd = ZERO_REG, counters 0.
- Each edge: mem_* <= ex_*.
  - ex_* <= id_* when id_valid && !stall.
  - Otherwise ex_* <= {ZERO_REG, 0, 0} (bubble).
- match(x, r) = x.regwrite && x.rd != ZERO_REG && x.rd == r.
- Load-use hazard: id_valid && ex.memread && ((id_use_rn && match(ex, id_rn)) || (id_use_rm && match(ex, id_rm))).
- CBZ hazard: id_valid && id_cbz && (match(ex, id_rm) || (mem.memread && match(mem, id_rm))).
  - Effect: CBZ after ALU op = 1 stall; CBZ directly after LDUR = 2 stalls; CBZ two after LDUR = 1 stall.
- stall = load_use || cbz_hazard.
- Outputs are combinational from the current ID inputs and the shadow registers (0-cycle latency):
  - stall=1: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. id_branch_taken is ignored while stalled.
  - stall=0 and id_valid && id_branch_taken: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=1.
  - Otherwise: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
  - id_valid=0: never stall or flush.
- Counters, each edge:
  - cnt_clear has priority and zeroes both counters.
  - Otherwise stall_cycles += stall and flush_cycles += ifid_flush.
  - Each counter saturates at all-ones (no wrap).
- Reset asserted mid-stall: shadows clear immediately, so stall drops in the same cycle and pc_write=1.
- ZERO_REG as destination never causes a hazard, even for LDUR X31.

Test Plan:
- LDUR X2 then ADD X3,X2,X4 (use_rn): stall=1 for exactly 1 cycle, idex_bubble=1, pc_write=0; next cycle stall=0; stall_cycles=1.
- ADD X5,... then CBZ X5: 1 stall cycle. LDUR X5 then CBZ X5: 2 consecutive stall cycles, stall_cycles=2.
- LDUR X31 then ADD using X31; and LDUR X2 then ADD with use_rn=0, rn=2: stall never asserts.
- Taken CBZ with no hazard: ifid_flush=1 for 1 cycle, flush_cycles=1. Taken CBZ arriving while hazard pending: ifid_flush=0 until stall clears, then 1.
- Force stall_cycles to all-ones (CNT_W=4, 16 stalls): counter holds 4'hF. Then cnt_clear coincident with stall: counter reads 0.
- Assert reset during second CBZ-after-load stall cycle: stall, idex_bubble=0 and pc_write=1 immediately; counters 0.
